muldiv_hilo_unit: RTL
=====================

Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline; owns the HI/LO architectural registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Drives stall_o into keep_i of the PC, IF/ID and ID/EX pipeline registers, so the muldiv instruction is held in EX until the result is committed.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, >=4)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  EX holds a valid muldiv instruction
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data_i  in  WIDTH  operand A / dividend
rt_data_i  in  WIDTH  operand B / divisor
mt_i  in  2  bit0 MTLO, bit1 MTHI
mt_data_i  in  WIDTH  MTHI/MTLO data
flush_i  in  1  abort in-flight operation (branch/exception clear)
stall_o  out  1  hold upstream pipeline regs (to keep_i)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, HI/LO just updated
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_i=1): state IDLE; hi_o, lo_o, done_o, busy_o = 0; stall_o forced 0 while rst_i high.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If mt_i != 0, write the selected HI and/or LO at the clock edge; start_i is ignored that cycle (mt wins).
  - Otherwise, start_i=1 latches op_i and operand magnitudes (absolute values for signed ops), records the sign flags, clears the iteration counter, and moves to RUN.
- stall_o = (IDLE & start_i & mt_i==0 & ~flush_i) | RUN. It is combinational so the first cycle is held.
- RUN: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - On the last RUN edge, apply sign fix-up and write HI/LO, then go to DONE.
- DONE: done_o=1, stall_o=0; start_i is ignored; next state IDLE. The instruction leaves EX at the end of DONE.
- Total EX residency: WIDTH+2 cycles; stall_o high for WIDTH+1 cycles.
- Results:
  - Multiply: {hi,lo} = 2*WIDTH product; signed product negated if operand signs differ.
  - Divide: lo = quotient, hi = remainder. Signed quotient is negated if signs differ; signed remainder takes the dividend's sign.
  - Divide by zero: no trap. Quotient = all ones (magnitude), remainder = dividend magnitude; signed fix-up still applied.
  - Signed overflow (min / -1): lo = min value, hi = 0.
- flush_i: in RUN, return to IDLE next edge; HI/LO unchanged; no done_o. In IDLE it suppresses a start. In DONE it has no effect, because HI/LO are already committed.
- mt_i is ignored outside IDLE.
- Reset mid-RUN: immediate return to the reset state; the partial result is discarded.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle combinational multiply. The sequence is IDLE -> DONE directly, HI/LO are written on the start edge, and stall_o is high for 1 cycle. Divide is unchanged.
- Undefined: all ops iterative as above.

Decomposition:
- Package mips_muldiv_pkg:
  - op_i encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - FSM state typedef (ST_IDLE, ST_RUN, ST_DONE)
  - MT bit positions
- One sub-module, muldiv_iter_core: accumulator/remainder registers, per-cycle shift-add / restore-subtract step, iteration counter, final sign fix-up.
- Top level: FSM, stall/done generation, HI/LO registers, mt writes.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> stall_o high 33 cycles, done_o pulse in cycle 34, hi=0xFFFFFFFE lo=0x00000001.
- MULT 0xFFFFFFFD (-3) * 5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIVU 100/7 -> lo=14 hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF hi=5, no hang, done_o after 34 cycles.
- Preload hi=0xA lo=0xB; start MULTU, flush_i at RUN cycle 10 -> stall_o low next cycle, no done_o, hi/lo stay 0xA/0xB. Separately, assert rst_i mid-RUN -> all outputs 0 without waiting for a clock edge.
- MTHI 0x1234 with start_i=1 in IDLE -> hi_o=0x1234 next cycle, lo unchanged, stall_o=0, no operation started. With MULDIV_FAST_MUL_EN defined, MULT 6*7 -> lo=42 after a 1-cycle stall.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: opcodes, FSM states, MT select bits.
// Op bit1 selects divide, op bit0 selects unsigned.
package mips_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int MT_LO_BIT = 0;
    localparam int MT_HI_BIT = 1;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// EX-stage <-> multiply/divide unit bundle; the unit side is the slave modport.
// Result and stall signals flow back to the pipeline via the master modport.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs_data_i;
    logic [WIDTH-1:0] rt_data_i;
    logic [1:0]       mt_i;
    logic [WIDTH-1:0] mt_data_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, rs_data_i, rt_data_i, mt_i, mt_data_i, flush_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_data_i, rt_data_i, mt_i, mt_data_i, flush_i,
        output stall_o, busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on operand magnitudes,
// WIDTH steps after load; res_*_o is the sign-corrected result of the step taken this cycle.
module muldiv_iter_core
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     trial;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;

    assign sign_a = op_is_signed(op_i) & a_i[WIDTH-1];
    assign sign_b = op_is_signed(op_i) & b_i[WIDTH-1];
    assign mag_a  = sign_a ? -a_i : a_i;
    assign mag_b  = sign_b ? -b_i : b_i;

    // Multiply: low half holds the remaining multiplier bits, high half the running sum.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign partial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial   = partial - {1'b0, opnd_q};
    assign div_ok  = ~trial[WIDTH];
    assign rem_new = div_ok ? trial[WIDTH-1:0] : partial[WIDTH-1:0];

    assign acc_step = is_div_q ? {rem_new, acc_q[WIDTH-2:0], div_ok}
                               : {mul_sum, acc_q[WIDTH-1:1]};

    assign prod_fix = neg_q ? -acc_step : acc_step;

    always_comb begin
        res_hi_o = prod_fix[2*WIDTH-1:WIDTH];
        res_lo_o = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            res_hi_o = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
            res_lo_o = neg_q     ? -acc_step[WIDTH-1:0]       : acc_step[WIDTH-1:0];
        end
    end

    assign last_o = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        if (load_i) begin
            acc_d     = {{WIDTH{1'b0}}, mag_a};
            opnd_d    = mag_b;
            cnt_d     = '0;
            is_div_d  = op_is_div(op_i);
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
        end else if (step_i) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// EX-stage MULT/MULTU/DIV/DIVU unit owning HI/LO: WIDTH+2 cycles in EX, stall_o held WIDTH+1.
// MULDIV_FAST_MUL_EN: multiplies complete combinationally on the start edge (1-cycle stall).
module muldiv_hilo_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    muldiv_hilo_unit_if.slave      bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             core_last;
    logic [WIDTH-1:0] core_hi, core_lo;

    // A start is taken only when no MT write competes and no flush is clearing EX.
    assign accept = (state_q == ST_IDLE) & bus.start_i & (bus.mt_i == 2'b00) & ~bus.flush_i;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{WIDTH{op_is_signed(bus.op_i) & bus.rs_data_i[WIDTH-1]}}, bus.rs_data_i};
    assign ext_b     = {{WIDTH{op_is_signed(bus.op_i) & bus.rt_data_i[WIDTH-1]}}, bus.rt_data_i};
    assign fast_prod = ext_a * ext_b;
`endif

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (accept),
        .step_i   ((state_q == ST_RUN) & ~bus.flush_i),
        .op_i     (bus.op_i),
        .a_i      (bus.rs_data_i),
        .b_i      (bus.rt_data_i),
        .last_o   (core_last),
        .res_hi_o (core_hi),
        .res_lo_o (core_lo)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.mt_i != 2'b00) begin
                    if (bus.mt_i[MT_LO_BIT]) lo_d = bus.mt_data_i;
                    if (bus.mt_i[MT_HI_BIT]) hi_d = bus.mt_data_i;
                end else if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    if (!op_is_div(bus.op_i)) begin
                        hi_d    = fast_prod[2*WIDTH-1:WIDTH];
                        lo_d    = fast_prod[WIDTH-1:0];
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else if (core_last) begin
                    hi_d    = core_hi;
                    lo_d    = core_lo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Combinational so the pipeline is frozen in the very cycle the start is seen.
    assign bus.stall_o = ~rst_i & (accept | (state_q == ST_RUN));
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.done_o  = (state_q == ST_DONE);
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule
